// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer: owns the PC, runs the fetch handshake and holds the instruction until execute retires it.
// Optional return stack (call/ret ports, stack_err) when PC_CALL_STACK_EN is defined.
module pc_sequencer #(
    parameter int              AW          = 8,
    parameter int              DW          = 8,
    parameter logic [AW-1:0]   RESET_PC    = '0
`ifdef PC_CALL_STACK_EN
    ,parameter int             STACK_DEPTH = 4
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run_i,
    input  logic          jmp_i,
    input  logic          pc_inc_i,
    input  logic [AW-1:0] jmp_addr_i,
    input  logic          step_done_i,
    input  logic          halt_i,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_data_i,
    output logic [DW-1:0] instr_o,
    output logic          instr_valid_o,
    output logic [AW-1:0] pc_o,
    output logic          halted_o
`ifdef PC_CALL_STACK_EN
    ,input  logic         call_i
    ,input  logic         ret_i
    ,output logic         stack_err_o
`endif
);

    // state   | meaning
    // S_IDLE  | parked, waiting for run
    // S_FETCH | mem_req high at pc, waiting for mem_ack
    // S_EXEC  | instr valid, waiting for step_done
    // S_HALT  | stopped until rst_n
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] instr_q, instr_d;
    logic          instr_valid_q, instr_valid_d;
    logic [AW-1:0] pc_plus1;

    assign pc_plus1 = pc_q + AW'(1);

`ifdef PC_CALL_STACK_EN
    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int PTRW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [AW-1:0]   stack_q [STACK_DEPTH];
    logic [SPW-1:0]  sp_q, sp_d;
    logic            err_q, err_d;
    logic            push;
    logic [PTRW-1:0] push_idx, pop_idx;
    logic            stack_full, stack_empty;

    assign push_idx    = PTRW'(sp_q);
    assign pop_idx     = PTRW'(sp_q - SPW'(1));
    assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
`ifdef PC_CALL_STACK_EN
        sp_d          = sp_q;
        err_d         = err_q;
        push          = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // run is not consulted here: a started fetch always completes
                if (mem_ack_i) begin
                    instr_d       = mem_data_i;
                    instr_valid_d = 1'b1;
                    state_d       = S_EXEC;
                end
            end
            S_EXEC: begin
                if (step_done_i) begin
                    instr_valid_d = 1'b0;
                    state_d       = run_i ? S_FETCH : S_IDLE;
                    if (halt_i) begin
                        state_d = S_HALT;
                    end
`ifdef PC_CALL_STACK_EN
                    else if (ret_i) begin
                        if (stack_empty) begin
                            err_d = 1'b1;
                            pc_d  = pc_plus1;
                        end else begin
                            sp_d = sp_q - SPW'(1);
                            pc_d = stack_q[pop_idx];
                        end
                    end
                    else if (call_i) begin
                        if (stack_full) begin
                            err_d = 1'b1;
                            pc_d  = pc_plus1;
                        end else begin
                            push = 1'b1;
                            sp_d = sp_q + SPW'(1);
                            pc_d = jmp_addr_i;
                        end
                    end
`endif
                    else if (jmp_i) begin
                        pc_d = jmp_addr_i;
                    end
                    else if (pc_inc_i) begin
                        pc_d = pc_plus1;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef PC_CALL_STACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
            if (push) begin
                stack_q[push_idx] <= pc_plus1;
            end
        end
    end

    assign stack_err_o = err_q;
`endif

    // mem_req decodes straight from state so an async reset drops it with no clock edge
    assign mem_req_o     = (state_q == S_FETCH);
    assign mem_addr_o    = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign pc_o          = pc_q;
    assign halted_o      = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer: a driver steps a PC model and queues expected fetch addresses and words,
// a memory responder acks with random latency, and a monitor checks every fetch and latched instruction.
module tb_pc_sequencer;
    localparam int          AW  = 8;
    localparam int          DW  = 8;
    localparam logic [7:0]  RPC = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0, jmp = 1'b0, pc_inc = 1'b0, step_done = 1'b0, halt = 1'b0;
    logic [7:0] jmp_addr = 8'h00;
    logic       mem_req, instr_valid, halted;
    logic [7:0] mem_addr, instr, pc;
    logic       ack_r = 1'b0, stray_ack = 1'b0;
    logic [7:0] data_r = 8'h00, stray_data = 8'h00;
    logic       mem_ack;
    logic [7:0] mem_data;
`ifdef PC_CALL_STACK_EN
    logic       call = 1'b0, ret = 1'b0, stack_err;
    bit         call_v = 1'b0, ret_v = 1'b0, exp_err = 1'b0;
    int         stk[$];
`endif

    assign mem_ack  = ack_r | stray_ack;
    assign mem_data = stray_ack ? stray_data : data_r;

    pc_sequencer #(.AW(AW), .DW(DW), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .run_i(run), .jmp_i(jmp), .pc_inc_i(pc_inc),
        .jmp_addr_i(jmp_addr), .step_done_i(step_done), .halt_i(halt),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
        .instr_o(instr), .instr_valid_o(instr_valid), .pc_o(pc), .halted_o(halted)
`ifdef PC_CALL_STACK_EN
        , .call_i(call), .ret_i(ret), .stack_err_o(stack_err)
`endif
    );

    always #5 clk = ~clk;

    int         n_cmp = 0, n_err = 0;
    logic [7:0] addr_q[$];
    logic [7:0] data_q[$];
    logic [7:0] last_instr = 8'h00;
    bit         ack_hold = 1'b0, hold_next = 1'b0, model_idle = 1'b1, req_seen = 1'b0, exp_valid = 1'b0;
    int         fixed_delay = 0, force_data = -1, wcnt = 0, cur_delay = 0;
    int         req_cycles = 0, last_req_cycles = 0;
    int         exp_pc = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory: acks after a per-request latency, logging each word it returns.
    always @(negedge clk) begin
        ack_r = 1'b0;
        if (rst_n && mem_req && !ack_hold) begin
            if (!req_seen) begin
                cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                req_seen  = 1'b1;
                wcnt      = 0;
            end
            if (wcnt >= cur_delay) begin
                ack_r      = 1'b1;
                data_r     = (force_data >= 0) ? 8'(force_data) : 8'($urandom);
                force_data = -1;
                data_q.push_back(data_r);
                req_seen   = 1'b0;
            end else begin
                wcnt++;
            end
        end
    end

    always @(negedge rst_n) begin
        req_seen   = 1'b0;
        wcnt       = 0;
        exp_valid  = 1'b0;
        req_cycles = 0;
    end

    // Monitor: every request cycle must show the queued address; each ack must latch its word next cycle.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (exp_valid) begin
                exp_valid = 1'b0;
                check("instr_valid_after_ack", instr_valid, 1);
                if (data_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL instr: got 0x%0h, expected no word pending", instr);
                end else begin
                    last_instr = data_q.pop_front();
                    check("instr", instr, last_instr);
                end
            end
            if (mem_req) begin
                req_cycles++;
                if (addr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_fetch: got mem_addr 0x%0h, expected no request", mem_addr);
                end else begin
                    check("mem_addr", mem_addr, addr_q[0]);
                end
                if (mem_ack) begin
                    if (addr_q.size() != 0) void'(addr_q.pop_front());
                    exp_valid       = 1'b1;
                    last_req_cycles = req_cycles;
                    req_cycles      = 0;
                end
            end
        end
    end

    task automatic do_step(bit h, bit j, bit inc, logic [7:0] a, bit r);
        int budget = 60;
        if (model_idle) run = 1'b1;
        while (!instr_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!instr_valid) begin
            n_cmp++; n_err++;
            $display("FAIL step_wait: got instr_valid 0, expected 1 within 60 cycles");
            return;
        end
        if ($urandom_range(0, 2) == 0) begin
            stray_ack  = 1'b1;
            stray_data = 8'($urandom);
            @(negedge clk);
            stray_ack  = 1'b0;
            check("exec_ignores_ack", instr, last_instr);
            check("exec_holds_valid", instr_valid, 1);
        end
        if (hold_next) ack_hold = 1'b1;
        halt = h; jmp = j; pc_inc = inc; jmp_addr = a; run = r; step_done = 1'b1;
`ifdef PC_CALL_STACK_EN
        call = call_v; ret = ret_v;
`endif
        @(negedge clk);
        step_done = 1'b0; halt = 1'b0;
        jmp = 1'($urandom); pc_inc = 1'($urandom); jmp_addr = 8'($urandom);
`ifdef PC_CALL_STACK_EN
        call = 1'b0; ret = 1'b0;
`endif
        if (h) begin
        end
`ifdef PC_CALL_STACK_EN
        else if (ret_v) begin
            if (stk.size() == 0) begin exp_err = 1'b1; exp_pc = (exp_pc + 1) % 256; end
            else exp_pc = stk.pop_back();
        end
        else if (call_v) begin
            if (stk.size() == 4) begin exp_err = 1'b1; exp_pc = (exp_pc + 1) % 256; end
            else begin stk.push_back((exp_pc + 1) % 256); exp_pc = int'(a); end
        end
`endif
        else if (j) exp_pc = int'(a);
        else if (inc) exp_pc = (exp_pc + 1) % 256;
        if (!h) addr_q.push_back(8'(exp_pc));
        model_idle = !r;
        check("pc_after_step", pc, exp_pc);
        check("valid_cleared", instr_valid, 0);
`ifdef PC_CALL_STACK_EN
        check("stack_err", stack_err, exp_err);
`endif
        if (h) begin
            check("halted", halted, 1);
            check("halt_no_req", mem_req, 0);
        end else if (!r) begin
            repeat (2) @(negedge clk);
            check("idle_no_req", mem_req, 0);
            check("idle_no_valid", instr_valid, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        force_data = 8'hA5;
        #12;
        check("rst_pc", pc, RPC);
        check("rst_instr", instr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_req", mem_req, 0);
        check("rst_halted", halted, 0);
`ifdef PC_CALL_STACK_EN
        check("rst_stack_err", stack_err, 0);
`endif
        exp_pc = int'(RPC);
        addr_q.push_back(RPC);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); run = 1'b1; model_idle = 1'b0;
        repeat (2) @(negedge clk);
        check("first_valid_latency", instr_valid, 1);
        check("first_instr", instr, 8'hA5);
        fixed_delay = -1;

        for (int i = 0; i < 60; i++) begin
            do_step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 4) != 0));
        end

        do_step(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1);
        do_step(1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
        do_step(1'b0, 1'b1, 1'b1, 8'h3C, 1'b1);
        do_step(1'b0, 1'b0, 1'b0, 8'h77, 1'b1);

        fixed_delay = 3;
        do_step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        run = 1'b0;
        do_step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("delayed_ack_req_cycles", last_req_cycles, 4);
        fixed_delay = -1;

`ifdef PC_CALL_STACK_EN
        do_step(1'b0, 1'b1, 1'b0, 8'h10, 1'b1);
        call_v = 1'b1;
        do_step(1'b0, 1'b0, 1'b0, 8'h40, 1'b1);
        call_v = 1'b0; ret_v = 1'b1;
        do_step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        ret_v = 1'b0; call_v = 1'b1;
        for (int i = 0; i < 5; i++) do_step(1'b0, 1'b0, 1'b0, 8'(8'h20 + i), 1'b1);
        call_v = 1'b0;
`endif

        do_step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step_done = 1'b1; jmp = 1'b1; jmp_addr = 8'h99; stray_ack = 1'b1; stray_data = 8'h66;
        repeat (3) @(negedge clk);
        step_done = 1'b0; stray_ack = 1'b0;
        @(negedge clk);
        check("halt_sticky", halted, 1);
        check("halt_pc_frozen", pc, exp_pc);
        check("halt_no_valid", instr_valid, 0);
        check("halt_no_req", mem_req, 0);

        #3 rst_n = 1'b0;
        #1;
        check("rst_clears_halt", halted, 0);
        check("rst_pc_async", pc, RPC);
        addr_q.delete(); data_q.delete();
        exp_pc = int'(RPC); model_idle = 1'b1; run = 1'b0;
`ifdef PC_CALL_STACK_EN
        stk.delete(); exp_err = 1'b0;
`endif
        @(negedge clk); rst_n = 1'b1;
        addr_q.push_back(RPC);
        do_step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        hold_next = 1'b1;
        do_step(1'b0, 1'b1, 1'b0, 8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        check("stalled_fetch_req", mem_req, 1);
        #3 rst_n = 1'b0;
        #1;
        check("midfetch_rst_req", mem_req, 0);
        check("midfetch_rst_pc", pc, RPC);
        check("midfetch_rst_valid", instr_valid, 0);
        addr_q.delete(); data_q.delete();
        ack_hold = 1'b0; hold_next = 1'b0; run = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and fetch sequencer; the consumer end of the jump-decision path.
- Takes the jmp / pc_inc decision and the jump target, owns the PC register, and runs the instruction-memory fetch handshake.
- Presents each fetched instruction to the execute stage and holds it until execute signals completion.

Parameters:
AW, 8, PC / memory address width
DW, 8, instruction width
RESET_PC, 0, PC value loaded on reset
STACK_DEPTH, 4, return-stack entries (CALL_STACK_EN only)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = sequencer may fetch/advance
jmp  input  1  jump decision; sampled on step_done
pc_inc  input  1  increment decision; sampled on step_done
jmp_addr  input  AW  jump target; sampled on step_done
step_done  input  1  one-cycle strobe: execute of current instr finished
halt  input  1  sampled on step_done; stop permanently
mem_req  output  1  fetch request to instruction memory
mem_addr  output  AW  fetch address (= pc)
mem_ack  input  1  memory returns mem_data this cycle
mem_data  input  DW  instruction word
instr  output  DW  registered instruction
instr_valid  output  1  instr holds a fetched, not-yet-retired instruction
pc  output  AW  current PC
halted  output  1  sequencer in HALT

Behaviour:
- Reset: the only reset is async active-low rst_n; all regs update on clk rising edge.
  - rst_n=0 gives: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, mem_req=0, halted=0.
  - Reset mid-fetch or mid-execute aborts immediately; no pending state survives.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE:
  - mem_req=0.
  - run=1 → FETCH on the next edge.
- FETCH:
  - mem_req=1; mem_addr=pc, stable until ack.
  - mem_ack=1 sampled → instr<=mem_data, instr_valid<=1, mem_req<=0, → EXEC.
  - Minimum request-to-instr_valid latency: 1 cycle (ack in the same cycle as the first req).
  - run dropping during FETCH does not abort; the fetch completes.
- EXEC:
  - instr and instr_valid held; step_done ignored in all other states.
  - On step_done: instr_valid<=0, then apply in priority order:
    - halt=1 → HALT; pc unchanged.
    - else jmp=1 → pc<=jmp_addr (jmp wins if jmp and pc_inc are both 1).
    - else pc_inc=1 → pc<=pc+1, modulo 2^AW (all-ones wraps to 0).
    - else (both 0) → pc held; the same address is re-fetched.
  - Next state after a non-halt step_done: FETCH if run=1, else IDLE.
  - mem_req stays 0 in EXEC; the next fetch's mem_req rises the cycle after step_done.
- HALT:
  - halted=1, mem_req=0, instr_valid=0; pc frozen.
  - Exit only via rst_n.
- mem_ack outside FETCH is ignored.

Optional Feature:
- Macro: PC_CALL_STACK_EN.
- Defined:
  - Extra ports call (in, 1), ret (in, 1), stack_err (out, 1, sticky, reset 0).
  - LIFO of STACK_DEPTH AW-bit entries.
  - call with step_done: push pc+1 (wrapped), then pc<=jmp_addr.
  - ret with step_done: pop into pc.
  - Priority: halt > ret > call > jmp > pc_inc.
  - Push when full or pop when empty: stack_err<=1, stack unchanged, pc<=pc+1.
- Undefined: no extra ports, no stack logic; behaviour exactly as above.

Test Plan:
- Reset/start: rst_n=0 then 1, run=1, RESET_PC=0 → next cycle mem_req=1, mem_addr=0x00; ack with mem_data=0xA5 → instr=0xA5, instr_valid=1 the next cycle.
- Increment and wrap: pc=0xFF in EXEC, step_done with pc_inc=1, jmp=0 → pc=0x00, next mem_addr=0x00.
- Jump priority: step_done with jmp=1, pc_inc=1, jmp_addr=0x3C → pc=0x3C; with jmp=0, pc_inc=0 → pc unchanged, same address re-fetched.
- Delayed ack and run drop: run=1, ack delayed 3 cycles → mem_req and mem_addr held 3 cycles. Drop run mid-fetch → fetch completes; after step_done, state IDLE and mem_req=0.
- Halt and async reset: step_done with halt=1 → halted=1, later step_done/mem_ack ignored. rst_n low mid-FETCH → mem_req=0 with no clock edge, pc=RESET_PC.
- PC_CALL_STACK_EN: call at pc=0x10, jmp_addr=0x40 → pc=0x40; ret → pc=0x11. Five nested calls (DEPTH=4) → stack_err=1, pc=pc+1.
